// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM states and MMIO register map.
// Offsets are byte offsets within the 64 KiB MMIO window.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] MMIO_OFF_LED  = 16'h0000;
  localparam logic [15:0] MMIO_OFF_CNT  = 16'h0004;
  localparam logic [15:0] MMIO_OFF_STAT = 16'h0008;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

endpackage

// File: rtl/dmem_responder_sp_ram.sv
// Single-port synchronous RAM, registered read (1 cycle), write-first not guaranteed.
// No reset on contents or output; the caller qualifies dout_o by its own timing.
module sp_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
    dout_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: wait-state RAM behind an IDLE/WAIT/DONE FSM (LATENCY+1 stall cycles),
// plus a zero-wait MMIO window (LED, cycle counter, sticky misalignment status).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic [15:0] led_o,
  output logic        addr_err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [31:0]       rdata_q;
  logic [15:0]       led_q;
  logic [31:0]       cyc_q;
  logic [31:0]       cyc_d;
  logic              err_q;

  logic              idle_req;
  logic              is_mis;
  logic              is_mmio;
  logic              ram_req;
  logic              mmio_wr;
  logic              mmio_rd;
  logic              commit;
  logic              ram_we;
  logic [15:0]       off;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_dout;
  logic [31:0]       mmio_rdata;

  assign idle_req = (state_q == ST_IDLE) && memenM;
  assign is_mis   = aluoutM[1:0] != 2'b00;
  assign is_mmio  = !is_mis && (aluoutM[31:16] == MMIO_BASE[31:16]);
  assign ram_req  = idle_req && !is_mis && !is_mmio;
  assign mmio_wr  = idle_req && is_mmio && memwriteM;
  assign mmio_rd  = idle_req && is_mmio && !memwriteM;
  assign off      = aluoutM[15:0];
  assign commit   = (state_q == ST_WAIT) && (cnt_q == '0);
  assign ram_we   = commit && we_q;
  assign stallM   = !rst && (ram_req || (state_q == ST_WAIT));
  assign cyc_d    = cyc_q + 32'd1;

  // Present the request address while IDLE so read data is ready on the first WAIT cycle;
  // nothing writes the RAM until commit, so dout stays valid through WAIT.
  assign ram_addr = (state_q == ST_IDLE) ? aluoutM[ADDR_W+1:2] : addr_q;

  sp_ram #(
    .AW (ADDR_W),
    .DW (32)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .din_i  (wdata_q),
    .dout_o (ram_dout)
  );

  always_comb begin
    mmio_rdata = 32'h0;
    case (off)
      MMIO_OFF_LED:  mmio_rdata = {16'h0, led_q};
      MMIO_OFF_CNT:  mmio_rdata = cyc_q;
      MMIO_OFF_STAT: mmio_rdata = {31'h0, err_q};
      default:       mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    readdataM = 32'h0;
    if (state_q == ST_DONE) begin
      readdataM = rdata_q;
    end else if (mmio_rd) begin
      readdataM = mmio_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ram_req) begin
            addr_q  <= aluoutM[ADDR_W+1:2];
            wdata_q <= writedataM;
            we_q    <= memwriteM;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              rdata_q <= ram_dout;
            end
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 16'h0;
      cyc_q <= 32'h0;
      err_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      if (mmio_wr && (off == MMIO_OFF_LED)) begin
        led_q <= writedataM[15:0];
      end
      // A new misalignment outranks a simultaneous clear.
      if (idle_req && is_mis) begin
        err_q <= 1'b1;
      end else if (mmio_wr && (off == MMIO_OFF_STAT) && writedataM[0]) begin
        err_q <= 1'b0;
      end
    end
  end

  assign led_o    = led_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, reset/wrap sequences, and a
// randomized run checked against a transaction-level model of memory, LED, status and counter.
module tb_dmem_responder;

  localparam int LAT        = 2;
  localparam int RAM_STALLS = LAT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic [15:0] led_o;
  logic        addr_err;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] tb_cyc = 32'h0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stalls;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_led;
    string       nm;
  } vec_t;

  vec_t vt[$];

  logic [31:0] mem_m [1024];
  bit          mem_v [1024];
  logic [15:0] led_m;
  logic        err_m;

  dmem_responder #(
    .ADDR_W    (10),
    .LATENCY   (LAT),
    .MMIO_BASE (32'hFFFF_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memwriteM  (memwriteM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .led_o      (led_o),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Every rising edge goes through here so the counter model stays in step.
  task automatic tick();
    @(posedge clk);
    if (rst) tb_cyc = 32'h0;
    else     tb_cyc = tb_cyc + 32'd1;
    @(negedge clk);
  endtask

  // One CPU access: hold the request until stallM drops, sample readdataM, then advance.
  task automatic mem_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd);
    memenM     = 1'b1;
    memwriteM  = we;
    aluoutM    = a;
    writedataM = d;
    stalls     = 0;
    #1;
    while (stallM === 1'b1 && stalls < 50) begin
      stalls++;
      tick();
      #1;
    end
    rd = readdataM;
    tick();
    memenM    = 1'b0;
    memwriteM = 1'b0;
  endtask

  task automatic idle(input int n);
    memenM    = 1'b0;
    memwriteM = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("idle_stall", {31'h0, stallM}, 32'h0);
      chk("idle_rdata", readdataM, 32'h0);
      tick();
    end
  endtask

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d, input int st,
                     input logic crd, input logic [31:0] erd, input logic eerr,
                     input logic [15:0] eled, input string nm);
    vt.push_back('{we, a, d, st, crd, erd, eerr, eled, nm});
  endtask

  initial begin
    int          st;
    logic [31:0] rd;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] exp;
    logic [31:0] a;
    logic [31:0] d;
    int          k;
    int          idx;

    // Reset with a RAM request pending: stall must stay low.
    rst        = 1'b1;
    memenM     = 1'b1;
    memwriteM  = 1'b0;
    aluoutM    = 32'h0000_0100;
    writedataM = 32'h0;
    tick();
    tick();
    #1;
    chk("rst_stall", {31'h0, stallM}, 32'h0);
    chk("rst_rdata", readdataM, 32'h0);
    chk("rst_led", {16'h0, led_o}, 32'h0);
    chk("rst_err", {31'h0, addr_err}, 32'h0);
    memenM = 1'b0;
    rst    = 1'b0;
    idle(2);

    add(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, RAM_STALLS, 1'b0, 32'h0,         1'b0, 16'h0,    "sw_ram");
    add(1'b0, 32'h0000_0100, 32'h0,         RAM_STALLS, 1'b1, 32'hDEAD_BEEF, 1'b0, 16'h0,    "lw_ram");
    add(1'b1, 32'hFFFF_0000, 32'h1234_ABCD, 0,          1'b1, 32'h0,         1'b0, 16'hABCD, "sw_led");
    add(1'b0, 32'hFFFF_0000, 32'h0,         0,          1'b1, 32'h0000_ABCD, 1'b0, 16'hABCD, "lw_led");
    add(1'b0, 32'h0000_0102, 32'h0,         0,          1'b1, 32'h0,         1'b1, 16'hABCD, "lw_mis");
    add(1'b0, 32'hFFFF_0008, 32'h0,         0,          1'b1, 32'h1,         1'b1, 16'hABCD, "lw_stat");
    add(1'b1, 32'hFFFF_0009, 32'h1,         0,          1'b1, 32'h0,         1'b1, 16'hABCD, "mis_no_clr");
    add(1'b1, 32'hFFFF_0008, 32'h1,         0,          1'b1, 32'h0,         1'b0, 16'hABCD, "stat_clr");
    add(1'b1, 32'hFFFF_000C, 32'h5555_5555, 0,          1'b1, 32'h0,         1'b0, 16'hABCD, "other_wr");
    add(1'b0, 32'hFFFF_000C, 32'h0,         0,          1'b1, 32'h0,         1'b0, 16'hABCD, "other_rd");
    add(1'b1, 32'h0000_0000, 32'h1111_1111, RAM_STALLS, 1'b0, 32'h0,         1'b0, 16'hABCD, "sw_0");
    add(1'b1, 32'h0000_0004, 32'h2222_2222, RAM_STALLS, 1'b0, 32'h0,         1'b0, 16'hABCD, "sw_4");
    add(1'b0, 32'h0000_0000, 32'h0,         RAM_STALLS, 1'b1, 32'h1111_1111, 1'b0, 16'hABCD, "lw_0");
    add(1'b0, 32'h0000_0004, 32'h0,         RAM_STALLS, 1'b1, 32'h2222_2222, 1'b0, 16'hABCD, "lw_4");
    add(1'b0, 32'h0000_1000, 32'h0,         RAM_STALLS, 1'b1, 32'h1111_1111, 1'b0, 16'hABCD, "lw_alias");
    add(1'b1, 32'h0000_0002, 32'h9999_9999, 0,          1'b1, 32'h0,         1'b1, 16'hABCD, "sw_mis");
    add(1'b0, 32'h0000_0000, 32'h0,         RAM_STALLS, 1'b1, 32'h1111_1111, 1'b1, 16'hABCD, "lw_0_kept");
    add(1'b1, 32'hFFFF_0008, 32'h0,         0,          1'b1, 32'h0,         1'b1, 16'hABCD, "stat_wr0");
    add(1'b1, 32'hFFFF_0008, 32'hFFFF_FFFF, 0,          1'b1, 32'h0,         1'b0, 16'hABCD, "stat_clr2");
    add(1'b1, 32'hFFFF_0004, 32'h0,         0,          1'b1, 32'h0,         1'b0, 16'hABCD, "cnt_wr_ign");
    add(1'b1, 32'h0000_0200, 32'h0,         RAM_STALLS, 1'b0, 32'h0,         1'b0, 16'hABCD, "sw_200");

    foreach (vt[i]) begin
      mem_op(vt[i].we, vt[i].addr, vt[i].wdata, st, rd);
      chk({vt[i].nm, "_stalls"}, 32'(st), 32'(vt[i].exp_stalls));
      if (vt[i].chk_rd) chk({vt[i].nm, "_rdata"}, rd, vt[i].exp_rd);
      chk({vt[i].nm, "_err"}, {31'h0, addr_err}, {31'h0, vt[i].exp_err});
      chk({vt[i].nm, "_led"}, {16'h0, led_o}, {16'h0, vt[i].exp_led});
    end

    // Cycle counter: absolute value, then two reads ten cycles apart.
    exp = tb_cyc;
    mem_op(1'b0, 32'hFFFF_0004, 32'h0, st, r1);
    chk("cnt_abs", r1, exp);
    chk("cnt_stalls", 32'(st), 32'h0);
    idle(9);
    mem_op(1'b0, 32'hFFFF_0004, 32'h0, st, r2);
    chk("cnt_delta", r2 - r1, 32'd10);

    // Reset pulse while a store sits in WAIT: must never be committed.
    memenM     = 1'b1;
    memwriteM  = 1'b1;
    aluoutM    = 32'h0000_0200;
    writedataM = 32'h0000_0055;
    #1;
    chk("rw_stall0", {31'h0, stallM}, 32'h1);
    tick();
    #1;
    chk("rw_stall1", {31'h0, stallM}, 32'h1);
    tick();
    #1;
    chk("rw_stall2", {31'h0, stallM}, 32'h1);
    rst    = 1'b1;
    tb_cyc = 32'h0;
    #1;
    chk("rw_rst_stall", {31'h0, stallM}, 32'h0);
    chk("rw_rst_led", {16'h0, led_o}, 32'h0);
    memenM    = 1'b0;
    memwriteM = 1'b0;
    tick();
    rst = 1'b0;
    idle(1);
    mem_op(1'b0, 32'h0000_0200, 32'h0, st, rd);
    chk("rw_lw_stalls", 32'(st), 32'(RAM_STALLS));
    chk("rw_lw_rdata", rd, 32'h0);

    // Counter wrap.
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    tb_cyc     = 32'hFFFF_FFFF;
    memenM     = 1'b1;
    memwriteM  = 1'b0;
    aluoutM    = 32'hFFFF_0004;
    #1;
    chk("wrap_pre", readdataM, 32'hFFFF_FFFF);
    tick();
    #1;
    chk("wrap_post", readdataM, tb_cyc);
    memenM = 1'b0;
    tick();

    // Randomized traffic against the transaction-level model.
    led_m = 16'h0;
    err_m = 1'b0;
    for (int i = 0; i < 1024; i++) mem_v[i] = 1'b0;
    for (int n = 0; n < 250; n++) begin
      k   = $urandom_range(0, 8);
      idx = $urandom_range(0, 15);
      a   = (32'($urandom_range(0, 15)) << 12) | (32'(idx) << 2);
      d   = $urandom;
      if (k == 1 && !mem_v[idx]) k = 0;
      case (k)
        0: begin
          mem_op(1'b1, a, d, st, rd);
          chk("rnd_sw_stalls", 32'(st), 32'(RAM_STALLS));
          mem_m[idx] = d;
          mem_v[idx] = 1'b1;
        end
        1: begin
          mem_op(1'b0, a, d, st, rd);
          chk("rnd_lw_stalls", 32'(st), 32'(RAM_STALLS));
          chk("rnd_lw_rdata", rd, mem_m[idx]);
        end
        2: begin
          mem_op(1'b1, 32'hFFFF_0000, d, st, rd);
          chk("rnd_ledw_stalls", 32'(st), 32'h0);
          led_m = d[15:0];
        end
        3: begin
          mem_op(1'b0, 32'hFFFF_0000, d, st, rd);
          chk("rnd_ledr_rdata", rd, {16'h0, led_m});
        end
        4: begin
          mem_op(1'b0, 32'hFFFF_0008, d, st, rd);
          chk("rnd_statr_rdata", rd, {31'h0, err_m});
        end
        5: begin
          a = {d[31:2], 2'(32'($urandom_range(1, 3)))};
          mem_op(1'($urandom_range(0, 1)), a, d, st, rd);
          chk("rnd_mis_stalls", 32'(st), 32'h0);
          chk("rnd_mis_rdata", rd, 32'h0);
          err_m = 1'b1;
        end
        6: begin
          mem_op(1'b1, 32'hFFFF_0008, d, st, rd);
          chk("rnd_statw_stalls", 32'(st), 32'h0);
          if (d[0]) err_m = 1'b0;
        end
        7: begin
          exp = tb_cyc;
          mem_op(1'b0, 32'hFFFF_0004, d, st, rd);
          chk("rnd_cnt_rdata", rd, exp);
        end
        default: idle($urandom_range(1, 3));
      endcase
      chk("rnd_led", {16'h0, led_o}, {16'h0, led_m});
      chk("rnd_err", {31'h0, addr_err}, {31'h0, err_m});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
